// File: rtl/keypad_scan_debounce.sv
// Row scanner and press/release debouncer for a 4x4 active-low matrix keypad.
// Accepts one key at a time and emits a single-cycle strobe with its mapped code.
module keypad_scan_debounce #(
   parameter int SETTLE_CYC   = 2,
   parameter int DEBOUNCE_CYC = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] col_matrix,
   output logic [3:0] lin_matrix,
   output logic [3:0] tecla_value,
   output logic       tecla_valid
);

   localparam int DW = $clog2(SETTLE_CYC + 1);
   localparam int CW = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [DW-1:0] DWELL_LAST = DW'(SETTLE_CYC - 1);
   localparam logic [DW-1:0] DWELL_ONE  = DW'(1);
   localparam logic [DW-1:0] DWELL_ZERO = DW'(0);
   localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_CYC);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      EMIT     = 2'd2,
      HOLD     = 2'd3
   } state_t;

   state_t        state_r, state_s;
   logic [1:0]    row_r, row_s;
   logic [DW-1:0] dwell_r, dwell_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [3:0]    pat_r, pat_s;
   logic [3:0]    lin_r;
   logic [3:0]    value_r;
   logic          valid_r;

   // True when exactly one column line is pulled low; ghosting/multi-key is rejected.
   function automatic logic single_low(input logic [3:0] cols);
      logic [3:0] low;
      low = ~cols;
      return (low != 4'h0) && ((low & (low - 4'h1)) == 4'h0);
   endfunction

   function automatic logic [3:0] key_code(input logic [1:0] row, input logic [3:0] pat);
      logic [1:0] col;
      logic [3:0] code;
      case (pat)
         4'b1110: col = 2'd0;
         4'b1101: col = 2'd1;
         4'b1011: col = 2'd2;
         4'b0111: col = 2'd3;
         default: col = 2'd0;
      endcase
      case ({row, col})
         4'd0:    code = 4'h1;
         4'd1:    code = 4'h2;
         4'd2:    code = 4'h3;
         4'd3:    code = 4'hA;
         4'd4:    code = 4'h4;
         4'd5:    code = 4'h5;
         4'd6:    code = 4'h6;
         4'd7:    code = 4'hB;
         4'd8:    code = 4'h7;
         4'd9:    code = 4'h8;
         4'd10:   code = 4'h9;
         4'd11:   code = 4'hC;
         4'd12:   code = 4'hE;
         4'd13:   code = 4'h0;
         4'd14:   code = 4'hF;
         4'd15:   code = 4'hD;
         default: code = 4'h0;
      endcase
      return code;
   endfunction

   // Next-state and counter logic for the scan/debounce/emit/hold sequence.
   always_comb begin
      state_s = state_r;
      row_s   = row_r;
      dwell_s = dwell_r;
      cnt_s   = cnt_r;
      pat_s   = pat_r;
      case (state_r)
         SCAN: begin
            if (dwell_r >= DWELL_LAST) begin
               dwell_s = DWELL_ZERO;
               if (single_low(col_matrix)) begin
                  pat_s   = col_matrix;
                  cnt_s   = CNT_ONE;
                  state_s = DEBOUNCE;
               end else begin
                  row_s = row_r + 2'd1;
               end
            end else begin
               dwell_s = dwell_r + DWELL_ONE;
            end
         end
         DEBOUNCE: begin
            if (col_matrix == pat_r) begin
               if (cnt_r >= CNT_DONE - CNT_ONE) begin
                  cnt_s   = CNT_DONE;
                  state_s = EMIT;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end else begin
               cnt_s   = CNT_ZERO;
               dwell_s = DWELL_ZERO;
               row_s   = row_r + 2'd1;
               state_s = SCAN;
            end
         end
         EMIT: begin
            cnt_s   = CNT_ZERO;
            state_s = HOLD;
         end
         HOLD: begin
            // Any low column on the held row restarts the release window.
            if (col_matrix == 4'hF) begin
               if (cnt_r >= CNT_DONE - CNT_ONE) begin
                  cnt_s   = CNT_ZERO;
                  dwell_s = DWELL_ZERO;
                  row_s   = row_r + 2'd1;
                  state_s = SCAN;
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end else begin
               cnt_s = CNT_ZERO;
            end
         end
         default: begin
            state_s = SCAN;
            row_s   = 2'd0;
            dwell_s = DWELL_ZERO;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // State, counters and registered outputs with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= SCAN;
         row_r   <= 2'd0;
         dwell_r <= DWELL_ZERO;
         cnt_r   <= CNT_ZERO;
         pat_r   <= 4'hF;
         lin_r   <= 4'b1110;
         value_r <= 4'h0;
         valid_r <= 1'b0;
      end else begin
         state_r <= state_s;
         row_r   <= row_s;
         dwell_r <= dwell_s;
         cnt_r   <= cnt_s;
         pat_r   <= pat_s;
         lin_r   <= ~(4'b0001 << row_s);
         valid_r <= (state_s == EMIT);
         if (state_s == EMIT) begin
            value_r <= key_code(row_r, pat_r);
         end else begin
            value_r <= value_r;
         end
      end
   end

   assign lin_matrix  = lin_r;
   assign tecla_value = value_r;
   assign tecla_valid = valid_r;

endmodule
